// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared encodings for the SRAM arbiter: FSM states, owner
//                identifiers, grant vector bit positions and idle bus values.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

   // Arbiter FSM state encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_CPU_OWN  = 2'd1;
   localparam state_t ST_LDR_OWN  = 2'd2;
   localparam state_t ST_LDR_LOCK = 2'd3;

   // Owner of the most recent grant (round-robin memory)
   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_LDR = 1'b1;

   // Bit positions inside the one-hot grant vector
   localparam int GNT_CPU = 0;
   localparam int GNT_LDR = 1;

   // SRAM bus values driven when no port is granted
   localparam logic [15:0] SRAM_IDLE_ADDR = 16'hFFFF;
   localparam logic [15:0] SRAM_IDLE_DATA = 16'h0000;

endpackage : sram_arbiter_pkg
`default_nettype wire

// File: rtl/sram_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_rr_pick
//  Description : 2-way round-robin selector. The port that was not granted
//                last wins a tie; force_cpu hands the slot to a requesting CPU
//                regardless of history. Output is one-hot (or zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter_rr_pick
   import sram_arbiter_pkg::*;
(
   input  logic       cpu_req,
   input  logic       ldr_req,
   input  logic       last_owner,
   input  logic       force_cpu,
   output logic [1:0] grant
);

   // CPU wins when forced, when alone, or when the loader went last
   always_comb begin
      grant = 2'b00;
      if (cpu_req && (force_cpu || !ldr_req || (last_owner == OWNER_LDR))) begin
         grant[GNT_CPU] = 1'b1;
      end else if (ldr_req) begin
         grant[GNT_LDR] = 1'b1;
      end
   end

endmodule : sram_arbiter_rr_pick
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Single-port SRAM arbiter between a CPU and a loader/debug
//                port. One access per grant, round-robin on ties, optional
//                loader lock with a burst limit that guarantees CPU service.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we_n,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic        cpu_rvalid,
   input  logic        ldr_req,
   input  logic        ldr_lock,
   input  logic        ldr_we_n,
   input  logic [15:0] ldr_addr,
   input  logic [15:0] ldr_wdata,
   output logic        ldr_gnt,
   output logic        ldr_rvalid,
   output logic [15:0] rdata,
   output logic [15:0] sram_addr,
   output logic [15:0] sram_q,
   output logic        sram_we_n,
   input  logic [15:0] sram_d
);

   localparam logic [7:0] MAX_BURST_CNT = 8'(MAX_BURST);

   state_t      state;
   state_t      state_nxt;
   logic        last_owner;
   logic [7:0]  burst_cnt;
   logic [1:0]  pick;
   logic        pick_last;
   logic        force_cpu;

   // In LDR_LOCK the loader takes every tie, modelled as "CPU went last"
   always_comb begin
      pick_last = (state == ST_LDR_LOCK) ? OWNER_CPU : last_owner;
      force_cpu = (burst_cnt >= MAX_BURST_CNT);
   end

   sram_arbiter_rr_pick rr_pick (
      .cpu_req    (cpu_req),
      .ldr_req    (ldr_req),
      .last_owner (pick_last),
      .force_cpu  (force_cpu),
      .grant      (pick)
   );

   // Output decode: grants (suppressed during reset) and SRAM bus mux
   always_comb begin
      cpu_gnt   = pick[GNT_CPU] & reset;
      ldr_gnt   = pick[GNT_LDR] & reset;
      sram_addr = SRAM_IDLE_ADDR;
      sram_q    = SRAM_IDLE_DATA;
      sram_we_n = 1'b1;
      if (cpu_gnt) begin
         sram_addr = cpu_addr;
         sram_q    = cpu_wdata;
         sram_we_n = cpu_we_n;
      end else if (ldr_gnt) begin
         sram_addr = ldr_addr;
         sram_q    = ldr_wdata;
         sram_we_n = ldr_we_n;
      end
   end

   // Next-state: follow the grant; a held lock survives a CPU slot
   always_comb begin
      state_nxt = ST_IDLE;
      if (cpu_gnt) begin
         state_nxt = ((state == ST_LDR_LOCK) && ldr_lock) ? ST_LDR_LOCK : ST_CPU_OWN;
      end else if (ldr_gnt) begin
         state_nxt = ldr_lock ? ST_LDR_LOCK : ST_LDR_OWN;
      end else if ((state == ST_LDR_LOCK) && ldr_lock) begin
         state_nxt = ST_LDR_LOCK;
      end
   end

   // State register and round-robin history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         last_owner <= OWNER_LDR;
      end else begin
         state <= state_nxt;
         if (cpu_gnt) begin
            last_owner <= OWNER_CPU;
         end else if (ldr_gnt) begin
            last_owner <= OWNER_LDR;
         end
      end
   end

   // Burst counter: loader grants taken while the CPU is kept waiting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         burst_cnt <= 8'd0;
      end else if (!cpu_req || cpu_gnt) begin
         burst_cnt <= 8'd0;
      end else if (ldr_gnt && (burst_cnt != 8'hFF)) begin
         burst_cnt <= burst_cnt + 8'd1;
      end
   end

   // Read capture: latch sram_d on a granted read, flag the owning port
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata      <= 16'h0000;
         cpu_rvalid <= 1'b0;
         ldr_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= cpu_gnt & cpu_we_n;
         ldr_rvalid <= ldr_gnt & ldr_we_n;
         if ((cpu_gnt && cpu_we_n) || (ldr_gnt && ldr_we_n)) begin
            rdata <= sram_d;
         end
      end
   end

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed self-checking bench for sram_arbiter (MAX_BURST=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we_n = 1'b1;
   logic [15:0] cpu_addr = '0, cpu_wdata = '0;
   logic        ldr_req = 1'b0, ldr_lock = 1'b0, ldr_we_n = 1'b1;
   logic [15:0] ldr_addr = '0, ldr_wdata = '0;
   logic [15:0] sram_d = '0;
   logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, sram_we_n;
   logic [15:0] rdata, sram_addr, sram_q;

   int checks = 0;
   int failures = 0;

   sram_arbiter #(.MAX_BURST(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we_n   (cpu_we_n),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .ldr_req    (ldr_req),
      .ldr_lock   (ldr_lock),
      .ldr_we_n   (ldr_we_n),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_gnt    (ldr_gnt),
      .ldr_rvalid (ldr_rvalid),
      .rdata      (rdata),
      .sram_addr  (sram_addr),
      .sram_q     (sram_q),
      .sram_we_n  (sram_we_n),
      .sram_d     (sram_d)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected grant pattern for the locked burst: C L L L L C L L
   logic [7:0] burst_cpu = 8'b0010_0001;  // bit i = cycle i

   initial begin
      // ---------------- reset state ----------------
      step();
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      check("rst_sram_addr", 32'(sram_addr), 32'hFFFF);
      check("rst_sram_q", 32'(sram_q), 32'h0);
      check("rst_sram_we_n", 32'(sram_we_n), 32'd1);
      reset = 1'b1;
      step();

      // ---------------- CPU read ----------------
      cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 16'h0010; sram_d = 16'h1234;
      #1;
      check("cpu_rd_gnt", 32'(cpu_gnt), 32'd1);
      check("cpu_rd_ldr_gnt", 32'(ldr_gnt), 32'd0);
      check("cpu_rd_addr", 32'(sram_addr), 32'h0010);
      check("cpu_rd_we_n", 32'(sram_we_n), 32'd1);
      step();
      cpu_req = 1'b0; sram_d = 16'h0000;
      #1;
      check("cpu_rd_rvalid", 32'(cpu_rvalid), 32'd1);
      check("cpu_rd_rdata", 32'(rdata), 32'h1234);
      check("cpu_rd_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
      check("cpu_rd_idle_gnt", 32'(cpu_gnt), 32'd0);
      check("cpu_rd_idle_addr", 32'(sram_addr), 32'hFFFF);
      step();
      check("cpu_rd_rvalid_1cyc", 32'(cpu_rvalid), 32'd0);
      check("cpu_rd_rdata_hold", 32'(rdata), 32'h1234);

      // ---------------- combinational deassertion ----------------
      cpu_req = 1'b1; cpu_addr = 16'h0044;
      #1;
      check("comb_gnt_on", 32'(cpu_gnt), 32'd1);
      cpu_req = 1'b0;
      #1;
      check("comb_gnt_off", 32'(cpu_gnt), 32'd0);
      check("comb_addr_off", 32'(sram_addr), 32'hFFFF);
      step();

      // ---------------- loader write ----------------
      ldr_req = 1'b1; ldr_we_n = 1'b0; ldr_addr = 16'h0200; ldr_wdata = 16'hBEEF;
      #1;
      check("ldr_wr_gnt", 32'(ldr_gnt), 32'd1);
      check("ldr_wr_we_n", 32'(sram_we_n), 32'd0);
      check("ldr_wr_addr", 32'(sram_addr), 32'h0200);
      check("ldr_wr_q", 32'(sram_q), 32'hBEEF);
      step();
      ldr_req = 1'b0;
      #1;
      check("ldr_wr_no_rvalid", 32'(ldr_rvalid), 32'd0);
      check("ldr_wr_idle_we_n", 32'(sram_we_n), 32'd1);
      step();

      // ---------------- reset during CPU read ----------------
      // make the loader the last owner's opposite first so the tie check below is meaningful
      cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 16'h0030; sram_d = 16'h5555;
      #1;
      check("abort_gnt", 32'(cpu_gnt), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("abort_gnt_in_rst", 32'(cpu_gnt), 32'd0);
      step();
      reset = 1'b1; cpu_req = 1'b0;
      #1;
      check("abort_no_rvalid", 32'(cpu_rvalid), 32'd0);
      check("abort_rdata", 32'(rdata), 32'h0);
      step();
      check("abort_no_rvalid2", 32'(cpu_rvalid), 32'd0);

      // ---------------- alternation from reset ----------------
      cpu_req = 1'b1; cpu_we_n = 1'b1; cpu_addr = 16'h0100;
      ldr_req = 1'b1; ldr_we_n = 1'b1; ldr_addr = 16'h0300; ldr_lock = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sram_d = 16'hA000 + 16'(i);
         #1;
         check($sformatf("alt_cpu_gnt%0d", i), 32'(cpu_gnt), 32'((i % 2) == 0));
         check($sformatf("alt_ldr_gnt%0d", i), 32'(ldr_gnt), 32'((i % 2) == 1));
         check($sformatf("alt_addr%0d", i), 32'(sram_addr), ((i % 2) == 0) ? 32'h0100 : 32'h0300);
         step();
         check($sformatf("alt_cpu_rv%0d", i), 32'(cpu_rvalid), 32'((i % 2) == 0));
         check($sformatf("alt_ldr_rv%0d", i), 32'(ldr_rvalid), 32'((i % 2) == 1));
         check($sformatf("alt_rdata%0d", i), 32'(rdata), 32'h0000A000 + 32'(i));
      end
      cpu_req = 1'b0; ldr_req = 1'b0;
      step();

      // ---------------- locked burst, MAX_BURST=4 ----------------
      cpu_req = 1'b1; ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         check($sformatf("burst_cpu_gnt%0d", i), 32'(cpu_gnt), 32'(burst_cpu[i]));
         check($sformatf("burst_ldr_gnt%0d", i), 32'(ldr_gnt), 32'(!burst_cpu[i]));
         step();
      end

      // locked, loader idle: CPU gets the slot
      ldr_req = 1'b0;
      #1;
      check("lock_cpu_when_ldr_idle", 32'(cpu_gnt), 32'd1);
      step();
      // lock alone grants nothing
      cpu_req = 1'b0;
      #1;
      check("lock_only_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("lock_only_ldr_gnt", 32'(ldr_gnt), 32'd0);
      step();
      ldr_lock = 1'b0;
      step();
      // back in IDLE with CPU last owner: an unlocked tie goes to the loader
      cpu_req = 1'b1; ldr_req = 1'b1;
      #1;
      check("post_lock_tie_ldr", 32'(ldr_gnt), 32'd1);
      check("post_lock_tie_cpu", 32'(cpu_gnt), 32'd0);
      step();
      cpu_req = 1'b0; ldr_req = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard against a hung run
   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule : tb_sram_arbiter
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 16, meaning max consecutive loader grants while the CPU waits (range 1..255).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_req  input  1  CPU access request.
REQ-005 cpu_we_n  input  1  CPU write enable, active-low.
REQ-006 cpu_addr  input  16  CPU word address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_gnt  output  1  CPU access issued to SRAM this cycle.
REQ-009 cpu_rvalid  output  1  CPU read data valid on rdata.
REQ-010 ldr_req  input  1  loader/debug access request.
REQ-011 ldr_lock  input  1  loader requests to keep ownership for a burst.
REQ-012 ldr_we_n  input  1  loader write enable, active-low.
REQ-013 ldr_addr  input  16  loader word address.
REQ-014 ldr_wdata  input  16  loader write data.
REQ-015 ldr_gnt  output  1  loader access issued to SRAM this cycle.
REQ-016 ldr_rvalid  output  1  loader read data valid on rdata.
REQ-017 rdata  output  16  registered SRAM read data, shared by both ports.
REQ-018 sram_addr  output  16  SRAM address.
REQ-019 sram_q  output  16  SRAM write data.
REQ-020 sram_we_n  output  1  SRAM write enable, active-low.
REQ-021 sram_d  input  16  SRAM read data, valid in the same cycle as sram_addr.

Function
REQ-022 FSM states SHALL be IDLE, CPU_OWN, LDR_OWN, LDR_LOCK; encoding lives in the shared package.
REQ-023 Each grant SHALL be exactly one SRAM access cycle; gnt is combinational from state plus req; at most one gnt is high per cycle.
REQ-024 While a port is granted, sram_addr/sram_q/sram_we_n SHALL mirror that port's inputs combinationally; with no grant: sram_addr=16'hFFFF, sram_q=16'h0000, sram_we_n=1.
REQ-025 A granted read (we_n=1) SHALL register sram_d into rdata at that clock edge and assert the port's rvalid for exactly the next cycle (latency 1); writes never assert rvalid.
REQ-026 Arbitration SHALL be round-robin on a last_owner bit: when both request in IDLE/CPU_OWN/LDR_OWN, the port not last granted wins; a lone requester always wins.
REQ-027 A loader grant with ldr_lock=1 SHALL enter LDR_LOCK; in LDR_LOCK the loader keeps priority on every cycle with ldr_req=1, and the CPU is granted only when ldr_req=0.
REQ-028 An 8-bit burst counter SHALL increment on each loader grant while cpu_req=1 and SHALL clear whenever cpu_req=0 or the CPU is granted.
REQ-029 When the counter reaches MAX_BURST, the next cycle SHALL grant the CPU if cpu_req=1, irrespective of ldr_lock, then return to LDR_LOCK if ldr_lock is still 1.
REQ-030 LDR_LOCK SHALL exit to IDLE when ldr_lock=0 and ldr_req=0; ldr_lock without ldr_req SHALL NOT grant.
REQ-031 Requesters SHALL hold req and payload stable until their gnt; the arbiter SHALL NOT latch payloads.
REQ-032 Simultaneous requests with last_owner=CPU SHALL grant the loader; same-cycle deassertion of req removes the grant combinationally.

Reset
REQ-033 On reset low: state=IDLE, last_owner=LDR (CPU wins first tie), burst counter=0, rdata=16'h0000, cpu_rvalid=ldr_rvalid=0, no gnt, SRAM outputs idle per REQ-024.
REQ-034 Reset asserted mid-access SHALL abort it; no rvalid SHALL follow after reset release.

Structure
REQ-035 State encoding, owner constants, and idle SRAM values (16'hFFFF address, 16'h0000 data) SHALL reside in the shared processor package used by control_fsm.
REQ-036 One sub-module SHALL be used: rr_pick (2-way round-robin selector: reqs + last_owner + force_cpu -> one-hot grant); everything else stays flat.

Verification
REQ-037 CPU only: read addr 16'h0010 with sram_d=16'h1234 -> cpu_gnt same cycle, cpu_rvalid=1 and rdata=16'h1234 next cycle.
REQ-038 Both requesting continuously, unlocked, from reset -> grants alternate CPU, LDR, CPU, LDR.
REQ-039 Loader locked burst, MAX_BURST=4, CPU requesting -> 4 ldr_gnt, 1 cpu_gnt, then ldr_gnt resumes.
REQ-040 Loader write addr 16'h0200 data 16'hBEEF -> sram_we_n=0, sram_addr=16'h0200, sram_q=16'hBEEF for one cycle; no ldr_rvalid.
REQ-041 Reset pulsed during a granted CPU read -> after release: no rvalid, rdata=0, state IDLE, first tie goes to the CPU.
